// File: rtl/dm_store_buf.sv
// dm_store_buf: two-entry store buffer between the CPU store port and data memory.
// Stores are lane-positioned on accept, drained in order, and snooped by pending loads.
// Optional misaligned-store rejection is enabled by defining DM_STORE_BUF_ALIGN_CHECK_EN.
module dm_store_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_sel,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [31:0] st_pc,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_pc,
    input  logic [31:0] ld_addr,
    output logic        ld_hit
`ifdef DM_STORE_BUF_ALIGN_CHECK_EN
    ,
    output logic        align_err
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    typedef struct packed {
        logic [29:0] word;
        logic [31:0] wdata;
        logic [3:0]  byteen;
        logic [31:0] pc;
    } entry_t;

    state_e     state_q, state_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    entry_t     entry_q [2];
    entry_t     entry_d [2];
    entry_t     new_entry;
    logic       misaligned;
    logic       enq;
    logic       deq;
    logic [1:0] occupied;
    logic       unused_ld_lsb;

    // Load snooping only compares word addresses.
    assign unused_ld_lsb = ^ld_addr[1:0];

    assign st_ready  = (state_q != StFull);
    assign mem_valid = (state_q != StEmpty);

`ifdef DM_STORE_BUF_ALIGN_CHECK_EN
    logic align_err_q, align_err_d;

    assign misaligned = ((st_sel == 2'b00) && (st_addr[1:0] != 2'b00)) ||
                        ((st_sel == 2'b01) && st_addr[0]);
    assign align_err_d = st_valid && st_ready && misaligned;
    assign align_err   = align_err_q;

    // One-cycle error pulse for a rejected misaligned request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    assign enq = st_valid && st_ready && (st_sel != 2'b11) && !misaligned;
    assign deq = mem_valid && mem_ready;

    // Translate the incoming store into a word address, lane data and byte enables.
    always_comb begin
        new_entry      = '0;
        new_entry.word = st_addr[31:2];
        new_entry.pc   = st_pc;
        case (st_sel)
            2'b00: begin
                new_entry.byteen = 4'b1111;
                new_entry.wdata  = st_data;
            end
            2'b01: begin
                new_entry.byteen = st_addr[1] ? 4'b1100 : 4'b0011;
                new_entry.wdata  = {2{st_data[15:0]}};
            end
            2'b10: begin
                new_entry.byteen = 4'b0001 << st_addr[1:0];
                new_entry.wdata  = {4{st_data[7:0]}};
            end
            default: begin
                new_entry.byteen = 4'b0000;
                new_entry.wdata  = '0;
            end
        endcase
    end

    // Next-state for occupancy, pointers and entry storage.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        entry_d  = entry_q;
        if (enq) begin
            entry_d[wr_ptr_q] = new_entry;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case (state_q)
            StEmpty: if (enq) state_d = StOne;
            StOne: begin
                if (enq && !deq) begin
                    state_d = StFull;
                end else if (!enq && deq) begin
                    state_d = StEmpty;
                end
            end
            StFull:  if (deq) state_d = StOne;
            default: state_d = StEmpty;
        endcase
    end

    // Buffer state; reset discards every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StEmpty;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            entry_q[0] <= '0;
            entry_q[1] <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            entry_q[0] <= entry_d[0];
            entry_q[1] <= entry_d[1];
        end
    end

    // Head entry drives the memory port and stays put until it is taken.
    always_comb begin
        mem_addr   = {entry_q[rd_ptr_q].word, 2'b00};
        mem_wdata  = entry_q[rd_ptr_q].wdata;
        mem_byteen = entry_q[rd_ptr_q].byteen;
        mem_pc     = entry_q[rd_ptr_q].pc;
    end

    // Load overlap against occupied entries only.
    always_comb begin
        occupied[0] = (state_q == StFull) || ((state_q == StOne) && !rd_ptr_q);
        occupied[1] = (state_q == StFull) || ((state_q == StOne) && rd_ptr_q);
        ld_hit      = (occupied[0] && (entry_q[0].word == ld_addr[31:2])) ||
                      (occupied[1] && (entry_q[1].word == ld_addr[31:2]));
    end

endmodule

// File: tb/tb_dm_store_buf.sv
// Testbench for dm_store_buf: scoreboard of expected memory writes plus per-scenario checks.
module tb_dm_store_buf;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_sel;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_pc;
    logic [31:0] ld_addr;
    logic        ld_hit;
`ifdef DM_STORE_BUF_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [99:0] exp_q[$];

    dm_store_buf u_dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_sel     (st_sel),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_pc      (st_pc),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_byteen (mem_byteen),
        .mem_pc     (mem_pc),
        .ld_addr    (ld_addr),
        .ld_hit     (ld_hit)
`ifdef DM_STORE_BUF_ALIGN_CHECK_EN
        ,
        .align_err  (align_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Expected memory write for an accepted store.
    function automatic logic [99:0] model(input logic [1:0] sel, input logic [31:0] a,
                                          input logic [31:0] d, input logic [31:0] pc);
        logic [3:0]  be;
        logic [31:0] w;
        case (sel)
            2'b00: begin be = 4'b1111; w = d; end
            2'b01: begin be = a[1] ? 4'b1100 : 4'b0011; w = {d[15:0], d[15:0]}; end
            2'b10: begin
                case (a[1:0])
                    2'd0: be = 4'b0001;
                    2'd1: be = 4'b0010;
                    2'd2: be = 4'b0100;
                    default: be = 4'b1000;
                endcase
                w = {d[7:0], d[7:0], d[7:0], d[7:0]};
            end
            default: begin be = 4'b0000; w = 32'h0; end
        endcase
        return {a[31:2], 2'b00, w, be, pc};
    endfunction

    // Scoreboard: every handshake on the memory port must match the oldest expected write.
    always @(negedge clk) begin
        if (reset && mem_valid && mem_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL drain_extra: got %h expected nothing",
                         {mem_addr, mem_wdata, mem_byteen, mem_pc});
            end else begin
                logic [99:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata, mem_byteen, mem_pc} !== e) begin
                    errors++;
                    $display("FAIL drain_order: got %h expected %h",
                             {mem_addr, mem_wdata, mem_byteen, mem_pc}, e);
                end
            end
        end
    end

    task automatic drive_store(input logic [1:0] sel, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] pc);
        st_valid = 1'b1;
        st_sel   = sel;
        st_addr  = a;
        st_data  = d;
        st_pc    = pc;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        st_valid = 1'b0; st_sel = 2'b11; st_addr = '0; st_data = '0; st_pc = '0;
        mem_ready = 1'b0; ld_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b need 0", mem_valid); end
        checks++;
        if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready: got %b need 1", st_ready); end
        checks++;
        if (ld_hit !== 1'b0) begin errors++; $display("FAIL reset_ld_hit: got %b need 0", ld_hit); end
        checks++;
        if ({mem_addr, mem_wdata, mem_byteen, mem_pc} !== 100'h0) begin
            errors++;
            $display("FAIL reset_mem_bus: got %h need 0", {mem_addr, mem_wdata, mem_byteen, mem_pc});
        end
`ifdef DM_STORE_BUF_ALIGN_CHECK_EN
        checks++;
        if (align_err !== 1'b0) begin errors++; $display("FAIL reset_align_err: got %b need 0", align_err); end
`endif
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_byte_store();
        mem_ready = 1'b1;
        drive_store(2'b10, 32'h0000_1003, 32'h0000_00AB, 32'h0000_0100);
        exp_q.push_back(model(2'b10, 32'h0000_1003, 32'h0000_00AB, 32'h0000_0100));
        @(posedge clk); #1;
        st_valid = 1'b0;
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL sb_present: valid %b addr %h need 1 00001000", mem_valid, mem_addr);
        end
        checks++;
        if (mem_byteen !== 4'b1000 || mem_wdata !== 32'hABAB_ABAB) begin
            errors++;
            $display("FAIL sb_lanes: be %b wdata %h need 1000 ababab", mem_byteen, mem_wdata);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_valid !== 1'b0) begin errors++; $display("FAIL sb_empty: got %b need 0", mem_valid); end
        // A no-store request must leave the buffer untouched.
        drive_store(2'b11, 32'h0000_5000, 32'h1111_1111, 32'h0000_0104);
        @(posedge clk); #1;
        st_valid = 1'b0;
        checks++;
        if (mem_valid !== 1'b0) begin errors++; $display("FAIL nostore_ignored: got %b need 0", mem_valid); end
    endtask

    task automatic test_full_stall();
        mem_ready = 1'b0;
        drive_store(2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0200);
        exp_q.push_back(model(2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0200));
        @(posedge clk); #1;
        drive_store(2'b01, 32'h0000_0016, 32'h0000_1234, 32'h0000_0204);
        exp_q.push_back(model(2'b01, 32'h0000_0016, 32'h0000_1234, 32'h0000_0204));
        @(posedge clk); #1;
        drive_store(2'b10, 32'h0000_0020, 32'h0000_0055, 32'h0000_0208);
        #1;
        checks++;
        if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b need 0", st_ready); end
        checks++;
        if (mem_addr !== 32'h0000_0010 || mem_byteen !== 4'b1111) begin
            errors++;
            $display("FAIL full_head: addr %h be %b need 00000010 1111", mem_addr, mem_byteen);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_0010 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL full_hold: valid %b addr %h wdata %h", mem_valid, mem_addr, mem_wdata);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (st_ready !== 1'b0) begin errors++; $display("FAIL full_no_pass: got %b need 0", st_ready); end
        @(posedge clk); #1;
        checks++;
        if (st_ready !== 1'b1 || mem_addr !== 32'h0000_0014 || mem_byteen !== 4'b1100 ||
            mem_wdata !== 32'h1234_1234) begin
            errors++;
            $display("FAIL full_second: ready %b addr %h be %b wdata %h",
                     st_ready, mem_addr, mem_byteen, mem_wdata);
        end
        exp_q.push_back(model(2'b10, 32'h0000_0020, 32'h0000_0055, 32'h0000_0208));
        @(posedge clk); #1;
        st_valid = 1'b0;
        checks++;
        if (mem_addr !== 32'h0000_0020 || mem_byteen !== 4'b0001 || mem_wdata !== 32'h5555_5555) begin
            errors++;
            $display("FAIL full_third: addr %h be %b wdata %h", mem_addr, mem_byteen, mem_wdata);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_drained: valid %b pending %0d need 0 0", mem_valid, exp_q.size());
        end
    endtask

    task automatic test_ld_hit();
        mem_ready = 1'b0;
        drive_store(2'b00, 32'h0000_2000, 32'h0000_0011, 32'h0000_0300);
        ld_addr = 32'h0000_2000;
        #1;
        checks++;
        if (ld_hit !== 1'b0) begin errors++; $display("FAIL ld_incoming: got %b need 0", ld_hit); end
        exp_q.push_back(model(2'b00, 32'h0000_2000, 32'h0000_0011, 32'h0000_0300));
        @(posedge clk); #1;
        st_valid = 1'b0;
        ld_addr = 32'h0000_2002;
        #1;
        checks++;
        if (ld_hit !== 1'b1) begin errors++; $display("FAIL ld_same_word: got %b need 1", ld_hit); end
        ld_addr = 32'h0000_2004;
        #1;
        checks++;
        if (ld_hit !== 1'b0) begin errors++; $display("FAIL ld_next_word: got %b need 0", ld_hit); end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        ld_addr = 32'h0000_2000;
        #1;
        checks++;
        if (mem_valid !== 1'b0 || ld_hit !== 1'b0) begin
            errors++;
            $display("FAIL ld_after_drain: valid %b hit %b need 0 0", mem_valid, ld_hit);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sel;
        logic [31:0] a;
        logic [31:0] d;
        mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sel = 2'(i % 3);
            a   = 32'h0000_3000 + 32'(i * 8);
            if (sel == 2'b01) a = a + 32'd2;
            if (sel == 2'b10) a = a + 32'(i % 4);
            d = $urandom;
            drive_store(sel, a, d, 32'h0000_0400 + 32'(i * 4));
            #1;
            checks++;
            if (st_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b need 1", i, st_ready); end
            exp_q.push_back(model(sel, a, d, 32'h0000_0400 + 32'(i * 4)));
            @(posedge clk); #1;
            checks++;
            if (mem_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b need 1", i, mem_valid); end
        end
        st_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drained: valid %b pending %0d need 0 0", mem_valid, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        drive_store(2'b00, 32'h0000_4000, 32'h0BAD_F00D, 32'h0000_0500);
        @(posedge clk); #1;
        drive_store(2'b00, 32'h0000_4004, 32'h0BAD_F00E, 32'h0000_0504);
        @(posedge clk); #1;
        st_valid = 1'b0;
        ld_addr = 32'h0000_4000;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_valid !== 1'b0 || st_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_flags: valid %b ready %b need 0 1", mem_valid, st_ready);
        end
        checks++;
        if (ld_hit !== 1'b0) begin errors++; $display("FAIL rst_mid_ld_hit: got %b need 0", ld_hit); end
        @(posedge clk); #1;
        drive_store(2'b01, 32'h0000_6002, 32'h0000_BEEF, 32'h0000_0508);
        #2;
        reset = 1'b1;
        exp_q.push_back(model(2'b01, 32'h0000_6002, 32'h0000_BEEF, 32'h0000_0508));
        @(posedge clk); #1;
        st_valid = 1'b0;
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_6000 || mem_byteen !== 4'b1100) begin
            errors++;
            $display("FAIL rst_release_store: valid %b addr %h be %b", mem_valid, mem_addr, mem_byteen);
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mem_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_drained: valid %b pending %0d need 0 0", mem_valid, exp_q.size());
        end
    endtask

    task automatic test_align();
        mem_ready = 1'b1;
        drive_store(2'b00, 32'h0000_0006, 32'hCAFE_F00D, 32'h0000_0600);
`ifdef DM_STORE_BUF_ALIGN_CHECK_EN
        #1;
        checks++;
        if (st_ready !== 1'b1) begin errors++; $display("FAIL align_ready: got %b need 1", st_ready); end
        @(posedge clk); #1;
        st_valid = 1'b0;
        checks++;
        if (align_err !== 1'b1 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL align_reject: err %b valid %b need 1 0", align_err, mem_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (align_err !== 1'b0 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL align_pulse: err %b valid %b need 0 0", align_err, mem_valid);
        end
`else
        exp_q.push_back(model(2'b00, 32'h0000_0006, 32'hCAFE_F00D, 32'h0000_0600));
        @(posedge clk); #1;
        st_valid = 1'b0;
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_0004 || mem_byteen !== 4'b1111) begin
            errors++;
            $display("FAIL align_ignored: valid %b addr %h be %b need 1 00000004 1111",
                     mem_valid, mem_addr, mem_byteen);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_valid !== 1'b0) begin errors++; $display("FAIL align_drained: got %b need 0", mem_valid); end
`endif
    endtask

    initial begin
        test_reset();
        test_byte_store();
        test_full_stall();
        test_ld_hit();
        test_back_to_back();
        test_reset_mid();
        test_align();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: pending %0d need 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
